// File: rtl/morse_pkg.sv
// Shared definitions for the Morse message sequencer: default sizes,
// controller state encoding and the letter lookup table.
package morse_pkg;

  localparam int unsigned PAT_W       = 11;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned MAX_LETTERS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Reference on/off patterns for letter codes 0..7 (A..H), MSB first:
  // dot = 1, dash = 111, one 0 between elements, zero padded.
  function automatic logic [PAT_W-1:0] ref_pattern(input logic [SEL_W-1:0] code);
    logic [PAT_W-1:0] p;
    case (code)
      3'd0:    p = 11'b10111000000; // A .-
      3'd1:    p = 11'b11101010100; // B -...
      3'd2:    p = 11'b11101011101; // C -.-.
      3'd3:    p = 11'b11101010000; // D -..
      3'd4:    p = 11'b10000000000; // E .
      3'd5:    p = 11'b10101110100; // F ..-.
      3'd6:    p = 11'b11101110100; // G --.
      default: p = 11'b10101010000; // H ....
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_shift_out.sv
// MSB-first parallel-load shift register with a bit counter that flags
// the last pattern bit. Zeros are shifted in, so once every bit has been
// shifted out the MSB (the LED drive) is left low.
module morse_shift_out #(
  parameter int unsigned PAT_W = morse_pkg::PAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] din_i,
  output logic             msb_o,
  output logic             last_o
);

  localparam int unsigned CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PAT_W - 1);

  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state: clear beats load beats shift; counter saturates on the last bit.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shreg_d = din_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q << 1;
      if (cnt_q != LAST_CNT) cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb_o  = shreg_q[PAT_W-1];
  assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/morse_msg_sequencer.sv
// Plays a multi-letter Morse message on one LED: fetches each letter's
// pattern from the external lookup, shifts it out one bit per tick and
// inserts an off gap between letters.
module morse_msg_sequencer #(
  parameter int unsigned PAT_W       = morse_pkg::PAT_W,
  parameter int unsigned SEL_W       = morse_pkg::SEL_W,
  parameter int unsigned MAX_LETTERS = morse_pkg::MAX_LETTERS,
  parameter int unsigned GAP_TICKS   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         stop,
  input  logic [SEL_W*MAX_LETTERS-1:0] msg,
  input  logic [3:0]                   msg_len,
  input  logic [PAT_W-1:0]             pattern,
  output logic [SEL_W-1:0]             letter_sel,
  output logic                         light,
  output logic                         busy,
  output logic                         done
);

  import morse_pkg::*;

  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [3:0] MAX_LEN = 4'(MAX_LETTERS);

  state_e                       state_q, state_d;
  logic [SEL_W*MAX_LETTERS-1:0] msg_q, msg_d;
  logic [3:0]                   len_q, len_d, len_in;
  logic [3:0]                   idx_q, idx_d, idx_inc;
  logic [GW-1:0]                gap_q, gap_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         busy_q, done_q;
  logic                         sh_clr, sh_load, sh_shift, sh_last, sh_msb;

  function automatic logic [SEL_W-1:0] letter_at(
    input logic [SEL_W*MAX_LETTERS-1:0] m,
    input logic [3:0]                   i
  );
    logic [SEL_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < MAX_LETTERS; k++) begin
      if (i == 4'(k)) r = m[k*SEL_W +: SEL_W];
    end
    return r;
  endfunction

  assign idx_inc = idx_q + 4'd1;

  // Controller next-state; stop overrides everything outside IDLE.
  // letter_sel is updated on entry to LOAD so it settles before the load tick.
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    len_d    = len_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    len_in   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          msg_d = msg;
          len_d = len_in;
          idx_d = '0;
          if (len_in == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            sel_d   = msg[SEL_W-1:0];
          end
        end
      end
      LOAD: begin
        if (tick) begin
          sh_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sh_shift = 1'b1;
          if (sh_last) begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
              state_d = DONE;
            end else if (GAP_TICKS == 0) begin
              state_d = LOAD;
              sel_d   = letter_at(msg_q, idx_inc);
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            state_d = LOAD;
            sel_d   = letter_at(msg_q, idx_q);
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      sh_clr  = 1'b1;
    end
  end

  // Controller registers; busy/done follow the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  morse_shift_out #(
    .PAT_W(PAT_W)
  ) u_shift (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (sh_clr),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .din_i   (pattern),
    .msb_o   (sh_msb),
    .last_o  (sh_last)
  );

  assign letter_sel = sel_q;
  assign light      = sh_msb;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Bench for morse_msg_sequencer: a tick-numbered message model checked
// against the DUT every cycle, plus directed scenarios with literal checks.
module tb_morse_msg_sequencer;
  import morse_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [23:0] msg   = '0;
  logic [3:0]  msg_len = '0;
  logic [10:0] pattern;
  logic [2:0]  letter_sel;
  logic        light, busy, done;

  int total = 0;
  int bad   = 0;

  morse_msg_sequencer #(
    .PAT_W(11), .SEL_W(3), .MAX_LETTERS(8), .GAP_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .msg(msg), .msg_len(msg_len), .pattern(pattern),
    .letter_sel(letter_sel), .light(light), .busy(busy), .done(done)
  );

  assign pattern = ref_pattern(letter_sel);

  always #5 clock = ~clock;

  // Tick every 4 clocks, driven on the falling edge.
  int tcnt = 0;
  always @(negedge clock) begin
    tcnt = (tcnt + 1) % 4;
    tick = (tcnt == 0);
  end

  // Model: each accepted message is a run of ticks numbered from 1. Letter i
  // occupies ticks 15i+1 .. 15i+11 (one pattern bit per tick, MSB first),
  // then 4 off ticks; the run ends on tick 15n-3 with a one-cycle done.
  int         m_phase = 0;  // 0 idle, 1 playing, 2 done cycle
  int         m_tick  = 0;
  int         m_n     = 0;
  logic [2:0] m_lets [8];
  logic       e_light = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [2:0] e_sel   = '0;

  always @(posedge clock) begin
    logic [10:0] p;
    int blk, off;
    if (reset) begin
      m_phase = 0; e_light = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sel = '0;
    end else begin
      case (m_phase)
        0: if (start && !stop) begin
          m_n = (msg_len > 4'd8) ? 8 : int'(msg_len);
          for (int k = 0; k < 8; k++) m_lets[k] = msg[3*k +: 3];
          m_tick = 0; e_light = 1'b0; e_busy = 1'b1;
          if (m_n == 0) begin
            m_phase = 2; e_done = 1'b1;
          end else begin
            m_phase = 1; e_sel = m_lets[0];
          end
        end
        1: if (stop) begin
          m_phase = 0; e_busy = 1'b0; e_light = 1'b0;
        end else if (tick) begin
          m_tick++;
          if (m_tick == 15 * m_n - 3) begin
            m_phase = 2; e_done = 1'b1; e_light = 1'b0;
          end else begin
            blk = (m_tick - 1) / 15;
            off = (m_tick - 1) % 15;
            p = ref_pattern(m_lets[blk]);
            e_light = (off < 11) ? p[10 - off] : 1'b0;
            e_sel = m_lets[m_tick / 15];
          end
        end
        default: begin
          m_phase = 0; e_done = 1'b0; e_busy = 1'b0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en     = 1'b0;
  int done_cnt   = 0;
  int light_cnt  = 0;
  int busy_ticks = 0;

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("light", light, e_light);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("letter_sel", letter_sel, e_sel);
        if (done === 1'b1) done_cnt++;
        if (light === 1'b1) light_cnt++;
      end
    end
  endtask

  task automatic tick_counter();
    forever begin
      @(posedge clock);
      if (tick && busy === 1'b1) busy_ticks++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); #1 start = 1'b1;
    @(negedge clock); #1 start = 1'b0;
  endtask

  task automatic next_tick();
    do @(posedge clock); while (tick !== 1'b1);
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clock);
      if (busy === 1'b0 && m_phase == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle_in_time"}, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, l0, k;
    logic [10:0] cap;
    fork
      compare_loop();
      tick_counter();
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    check("rst_light", light, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", letter_sel, 0);
    #1 reset = 1'b0;

    // Single letter A
    msg = 24'o00000000; msg_len = 4'd1; d0 = done_cnt; busy_ticks = 0;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      next_tick();
      cap[10 - i] = light;
    end
    check("A_pattern", cap, 11'b10111000000);
    wait_idle("A", 200);
    check("A_done_count", done_cnt - d0, 1);
    check("A_ticks", busy_ticks, 12);

    // Two letters A then B
    msg = 24'o00000010; msg_len = 4'd2; d0 = done_cnt; busy_ticks = 0;
    pulse_start();
    check("AB_sel_first", letter_sel, 0);
    wait_idle("AB", 400);
    check("AB_done_count", done_cnt - d0, 1);
    check("AB_ticks", busy_ticks, 27);
    check("AB_sel_last", letter_sel, 1);

    // Empty message
    msg_len = 4'd0; l0 = light_cnt; d0 = done_cnt;
    @(negedge clock); #1 start = 1'b1;
    @(negedge clock);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    #1 start = 1'b0;
    @(negedge clock);
    check("len0_done_gone", done, 0);
    check("len0_busy_gone", busy, 0);
    check("len0_no_light", light_cnt - l0, 0);
    check("len0_done_count", done_cnt - d0, 1);

    // Length clamp: 12 requested, 8 played
    msg = 24'o76543210; msg_len = 4'd12; d0 = done_cnt; busy_ticks = 0;
    pulse_start();
    wait_idle("clamp", 1200);
    check("clamp_ticks", busy_ticks, 117);
    check("clamp_done_count", done_cnt - d0, 1);
    check("clamp_sel_last", letter_sel, 7);

    // Stop in the 2nd letter's SHIFT, coincident with a tick
    msg = 24'o00000010; msg_len = 4'd2; d0 = done_cnt;
    pulse_start();
    k = 0;
    while (k < 400) begin
      @(negedge clock); #1;
      if (tick && m_tick == 19) break;
      k++;
    end
    check("stop_reached", (k < 400), 1);
    stop = 1'b1;
    @(negedge clock);
    check("stop_busy", busy, 0);
    check("stop_light", light, 0);
    check("stop_done", done, 0);
    #1 stop = 1'b0;
    repeat (8) @(negedge clock);
    check("stop_no_done", done_cnt - d0, 0);
    pulse_start();
    check("restart_sel", letter_sel, 0);
    next_tick();
    check("restart_first_bit", light, 1);
    wait_idle("restart", 400);
    check("restart_done_count", done_cnt - d0, 1);

    // Start and msg changes while busy are ignored
    msg = 24'o00000010; msg_len = 4'd2; d0 = done_cnt; busy_ticks = 0;
    pulse_start();
    repeat (3) next_tick();
    msg = 24'o77777777; msg_len = 4'd5;
    pulse_start();
    wait_idle("busy_start", 400);
    check("busy_start_ticks", busy_ticks, 27);
    check("busy_start_done_count", done_cnt - d0, 1);

    // Tick coincident with start: that tick is not counted
    msg = 24'o00000001; msg_len = 4'd1; busy_ticks = 0;
    k = 0;
    do begin
      @(negedge clock); #1;
      k++;
    end while (tick !== 1'b1 && k < 10);
    start = 1'b1;
    @(negedge clock);
    check("coinc_busy", busy, 1);
    check("coinc_no_bit", light, 0);
    #1 start = 1'b0;
    next_tick();
    check("coinc_first_bit", light, 1);
    wait_idle("coinc", 200);
    check("coinc_ticks", busy_ticks, 12);

    // Reset mid-SHIFT
    msg = 24'o00000000; msg_len = 4'd1; d0 = done_cnt;
    pulse_start();
    repeat (3) next_tick();
    check("pre_reset_busy", busy, 1);
    #1 reset = 1'b1;
    @(negedge clock);
    check("mid_rst_light", light, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sel", letter_sel, 0);
    #1 reset = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_rst_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_msg_sequencer.md
Name: morse_msg_sequencer

Overview:
Controller that plays a multi-letter Morse message on one LED. It steps through up to MAX_LETTERS 3-bit letter codes. For each letter it drives the code to the existing letter lookup (select) and captures the returned 11-bit pattern. It then shifts the pattern out one bit per half-second tick from the down-counter and inserts an off gap between letters. It replaces the single-letter KEY/SW load logic in the top level.

Parameters:
PAT_W, 11, pattern width from the letter lookup; sent MSB first.
SEL_W, 3, letter code width.
MAX_LETTERS, 8, message capacity.
GAP_TICKS, 3, off ticks inserted between consecutive letters.

Ports:
clock  input  1  system clock (CLOCK_50 domain).
reset  input  1  synchronous, active-high reset.
tick  input  1  one-cycle enable pulse from the down-counter (bit period).
start  input  1  level/pulse; sampled only in IDLE.
stop  input  1  abort; valid in any state.
msg  input  SEL_W*MAX_LETTERS  letter codes; letter 0 in bits [SEL_W-1:0], played first.
msg_len  input  4  number of letters to play, 0..15.
pattern  input  PAT_W  combinational pattern returned for letter_sel.
letter_sel  output  SEL_W  code of the current letter, driven to the lookup.
light  output  1  LED drive (LEDR[0]).
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: state=IDLE; light=0, busy=0, done=0, letter_sel=0; shift register, bit counter, gap counter and letter index all cleared. Reset overrides every other input, including mid-message.
- All outputs are registered.
- States: IDLE, LOAD, SHIFT, GAP, DONE.
- IDLE, on start=1 with stop=0:
  - latch msg into msg_q; latch len_q = min(msg_len, MAX_LETTERS); idx=0.
  - If len_q==0, go to DONE; otherwise go to LOAD.
- LOAD:
  - letter_sel = msg_q[idx]; light=0.
  - Wait for tick. On tick: shreg<=pattern, bit_cnt<=0, go to SHIFT.
  - pattern is sampled the same cycle as tick; letter_sel is stable at least one cycle earlier.
- SHIFT:
  - light = shreg[PAT_W-1].
  - On tick with bit_cnt<PAT_W-1: shift left, fill 0, bit_cnt++.
  - On tick with bit_cnt==PAT_W-1: light<=0, idx++. If idx+1==len_q, go to DONE; otherwise gap_cnt<=0 and go to GAP.
  - Each pattern bit is held for exactly one full tick period.
- GAP:
  - light=0.
  - On tick: gap_cnt++. When gap_cnt reaches GAP_TICKS-1 on a tick, go to LOAD.
  - GAP_TICKS=0 skips GAP and goes directly to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- stop=1 in any non-IDLE state: next cycle state=IDLE, light=0, busy=0, no done pulse.
  - stop has priority over tick and start in the same cycle.
- start while busy: ignored; msg/msg_len changes while busy have no effect.
- tick and start in the same IDLE cycle: start accepted; the tick is not counted, and the first letter waits for the next tick in LOAD.
- Ticks in IDLE or DONE: ignored.
- Letter timing: latency from start to first light bit is up to 1 tick period; total ticks per letter = PAT_W; inter-letter off = 1 (LOAD wait) + GAP_TICKS ticks.
- Counter widths: bit_cnt ceil(log2(PAT_W)), gap_cnt ceil(log2(GAP_TICKS+1)), idx 4 bits; no wrap is possible under the clamp.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding typedef (IDLE/LOAD/SHIFT/GAP/DONE);
  - PAT_W, SEL_W, MAX_LETTERS constants;
  - bench reference patterns for codes 0..7.
- One natural sub-module: morse_shift_out. It is the PAT_W parallel-load, MSB-first shift register with load/shift enables and a bit counter that flags the last bit.
- The FSM, letter indexing and gap counting stay in the top.

Test Plan:
- Bench model pattern(0)=10111000000 (A) and pattern(1)=11101010100 (B); tick every 4 clocks.
- Reset mid-SHIFT -> next cycle light=0, busy=0, state IDLE, no done pulse.
- Single letter, msg_len=1, msg[2:0]=0, start -> after first tick light follows 1,0,1,1,1,0,0,0,0,0,0 one bit per tick; done pulses once, 11 ticks after load; busy falls the cycle after done.
- Two letters, msg=(1,0), msg_len=2, GAP_TICKS=3 -> A pattern; light=0 for 4 ticks; B pattern; single done pulse; letter_sel=0 then 1.
- msg_len=0 -> done pulses 2 cycles after start, light never 1. msg_len=12 -> exactly 8 letters played.
- stop asserted during the 2nd letter's SHIFT, same cycle as tick -> next cycle IDLE, light=0, done never asserted; a fresh start then replays from letter 0.
- start pulsed while busy, with msg changed mid-message -> original message continues unchanged; tick coincident with start in IDLE -> first light bit appears on the following tick, not the coincident one.
